rom_port_arbiter: RTL and testbench

Shares the single combinational read port of the program ROM between two requesters: the instruction-fetch stage (IF) and the load unit (LS, for constant loads from ROM). Accepts address requests with valid/ready, drives the ROM address, and captures the ROM word into a per-port response register with valid/ready backpressure. Arbitration is LS-priority with a bounded starvation guarantee for IF. It also flags misaligned or out-of-range accesses.

---
 rtl/rom_port_arbiter_pkg.sv | 11 +
 rtl/rom_rsp_slot.sv | 28 ++
 rtl/rom_port_arbiter.sv | 65 ++++++
 tb/tb_rom_port_arbiter.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/rom_port_arbiter_pkg.sv
// rom_port_arbiter_pkg: shared ROM geometry, grant encoding and the access check
package rom_port_arbiter_pkg;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int ROM_WORDS_DEF = 100;
  typedef enum logic [1:0] {GNT_NONE, GNT_IF, GNT_LS} grant_t;
  // Addresses are widened to 64 bits so one function serves any ADDR_W up to 64.
  function automatic logic rom_err_check(input logic [63:0] addr, input int words);
    return addr[1:0] != 2'b00 || addr[63:2] >= 62'(words);
  endfunction
endpackage

// File: rtl/rom_rsp_slot.sv
// rom_rsp_slot: one-deep response register with valid/ready handshake
module rom_rsp_slot #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_err,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              err
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      data  <= '0;
      err   <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      err   <= load_err;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares the ROM read port between IF and LS with LS priority
// and a bounded IF starvation window.
module rom_port_arbiter
  import rom_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ROM_WORDS  = ROM_WORDS_DEF,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_rsp_valid,
  input  logic              if_rsp_ready,
  output logic [DATA_W-1:0] if_rsp_data,
  output logic              if_rsp_err,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic [ADDR_W-1:0] ls_req_addr,
  output logic              ls_rsp_valid,
  input  logic              ls_rsp_ready,
  output logic [DATA_W-1:0] ls_rsp_data,
  output logic              ls_rsp_err,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] starve_cnt;
  logic if_elig, ls_elig, hit_err;
  logic [DATA_W-1:0] rsp_word;
  grant_t grant;
  // Eligibility is gated by reset so neither port is granted while reset_n is low.
  always_comb begin
    if_elig  = reset_n && if_req_valid && (!if_rsp_valid || if_rsp_ready);
    ls_elig  = reset_n && ls_req_valid && (!ls_rsp_valid || ls_rsp_ready);
    grant    = (if_elig && ls_elig) ? (starve_cnt < CW'(STARVE_MAX) ? GNT_LS : GNT_IF)
             : if_elig ? GNT_IF : ls_elig ? GNT_LS : GNT_NONE;
    rom_addr = grant == GNT_IF ? if_req_addr : grant == GNT_LS ? ls_req_addr : '0;
    hit_err  = rom_err_check(64'(rom_addr), ROM_WORDS);
    rsp_word = hit_err ? '0 : rom_data;
  end
  assign if_req_ready = grant == GNT_IF;
  assign ls_req_ready = grant == GNT_LS;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      starve_cnt <= '0;
    else if (!if_req_valid || grant == GNT_IF)
      starve_cnt <= '0;
    else if (if_elig && grant == GNT_LS && starve_cnt < CW'(STARVE_MAX))
      starve_cnt <= starve_cnt + 1'b1;
  end
  rom_rsp_slot #(.DATA_W(DATA_W)) u_if_slot (
    .clk(clk), .reset_n(reset_n), .load(if_req_ready), .load_data(rsp_word),
    .load_err(hit_err), .ready(if_rsp_ready), .valid(if_rsp_valid),
    .data(if_rsp_data), .err(if_rsp_err)
  );
  rom_rsp_slot #(.DATA_W(DATA_W)) u_ls_slot (
    .clk(clk), .reset_n(reset_n), .load(ls_req_ready), .load_data(rsp_word),
    .load_err(hit_err), .ready(ls_rsp_ready), .valid(ls_rsp_valid),
    .data(ls_rsp_data), .err(ls_rsp_err)
  );
endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter: scoreboard bench with a behavioural arbitration and ROM model
module tb_rom_port_arbiter;
  localparam int SM = 4;
  localparam int WORDS = 100;
  logic clk = 1'b0, reset_n = 1'b0;
  logic if_req_valid = 0, if_req_ready, if_rsp_valid, if_rsp_ready = 0, if_rsp_err;
  logic ls_req_valid = 0, ls_req_ready, ls_rsp_valid, ls_rsp_ready = 0, ls_rsp_err;
  logic [31:0] if_req_addr = 0, ls_req_addr = 0, if_rsp_data, ls_rsp_data, rom_addr, rom_data;
  logic [31:0] mem [128];
  logic [32:0] if_q[$], ls_q[$];
  logic held_if = 0, held_ls = 0;
  int losses = 0, checks = 0, failures = 0, dut_if_grants = 0;

  rom_port_arbiter #(.ADDR_W(32), .DATA_W(32), .ROM_WORDS(WORDS), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready), .if_rsp_data(if_rsp_data),
    .if_rsp_err(if_rsp_err),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_addr(ls_req_addr),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_ready(ls_rsp_ready), .ls_rsp_data(ls_rsp_data),
    .ls_rsp_err(ls_rsp_err),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );

  always #5 clk = ~clk;
  assign rom_data = (rom_addr[31:2] < 30'd100) ? mem[rom_addr[8:2]] : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] expect_rsp(input logic [31:0] a);
    if (a % 4 != 0 || a / 4 >= WORDS) return {1'b1, 32'h0};
    return {1'b0, mem[a / 4]};
  endfunction

  function automatic logic [31:0] rand_addr();
    int r = $urandom_range(0, 9);
    logic [31:0] a = 4 * $urandom_range(0, WORDS - 1);
    if (r == 7) return a + $urandom_range(1, 3);
    if (r == 8) return 4 * $urandom_range(WORDS, WORDS + 20);
    if (r == 9) return $urandom;
    return a;
  endfunction

  task automatic check_reset_outputs();
    chk("rst_if_req_ready", if_req_ready, 0);
    chk("rst_ls_req_ready", ls_req_ready, 0);
    chk("rst_if_rsp_valid", if_rsp_valid, 0);
    chk("rst_ls_rsp_valid", ls_rsp_valid, 0);
    chk("rst_if_rsp", {if_rsp_err, if_rsp_data}, 0);
    chk("rst_ls_rsp", {ls_rsp_err, ls_rsp_data}, 0);
    chk("rst_rom_addr", rom_addr, 0);
  endtask

  // One clock of stimulus: check grant against the model and push expected responses.
  task automatic step(input logic iv, input logic [31:0] ia, input logic ir,
                      input logic lv, input logic [31:0] la, input logic lr);
    logic ie, le;
    int g;
    if_req_valid = iv; if_req_addr = ia; if_rsp_ready = ir;
    ls_req_valid = lv; ls_req_addr = la; ls_rsp_ready = lr;
    @(negedge clk); #1;
    ie = iv && (!held_if || ir);
    le = lv && (!held_ls || lr);
    g = (ie && le) ? (losses >= SM ? 1 : 2) : ie ? 1 : le ? 2 : 0;
    chk("if_req_ready", if_req_ready, g == 1);
    chk("ls_req_ready", ls_req_ready, g == 2);
    chk("rom_addr", rom_addr, g == 1 ? ia : g == 2 ? la : 32'h0);
    if (if_req_ready) dut_if_grants++;
    if (g == 1) if_q.push_back(expect_rsp(ia));
    if (g == 2) ls_q.push_back(expect_rsp(la));
    losses  = (!iv || g == 1) ? 0 : (ie && g == 2 && losses < SM) ? losses + 1 : losses;
    held_if = g == 1 ? 1'b1 : ir ? 1'b0 : held_if;
    held_ls = g == 2 ? 1'b1 : lr ? 1'b0 : held_ls;
    @(posedge clk); #1;
  endtask

  // Monitor: response presence must match the scoreboard, and the held word must match its front.
  initial forever begin
    @(negedge clk);
    chk("if_rsp_valid", if_rsp_valid, if_q.size() > 0);
    if (if_rsp_valid && if_q.size() > 0) begin
      chk("if_rsp", {if_rsp_err, if_rsp_data}, if_q[0]);
      if (if_rsp_ready) void'(if_q.pop_front());
    end
    chk("ls_rsp_valid", ls_rsp_valid, ls_q.size() > 0);
    if (ls_rsp_valid && ls_q.size() > 0) begin
      chk("ls_rsp", {ls_rsp_err, ls_rsp_data}, ls_q[0]);
      if (ls_rsp_ready) void'(ls_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    if_req_valid = 1; ls_req_valid = 1; if_req_addr = 4; ls_req_addr = 8;
    #3 check_reset_outputs();
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1;
    step(1, 32'h0, 1, 0, 0, 1);
    step(1, 32'h4, 1, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1);
    step(0, 0, 1, 1, 32'h2, 1);
    step(0, 0, 1, 1, 32'h190, 1);
    step(0, 0, 1, 1, 32'h18C, 1);
    step(0, 0, 1, 0, 0, 1);
    step(1, 32'h10, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 32'h14, 0, 0, 0, 1);
    step(1, 32'h14, 1, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1);
    dut_if_grants = 0;
    for (int k = 0; k < 20; k++) step(1, 4 * k, 1, 1, 4 * (k + 50), 1);
    chk("if_grants_in_20", dut_if_grants, 4);
    step(0, 0, 1, 0, 0, 1);
    for (int k = 0; k < 600; k++)
      step($urandom_range(0, 9) < 7, rand_addr(), $urandom_range(0, 9) < 7,
           $urandom_range(0, 9) < 7, rand_addr(), $urandom_range(0, 9) < 7);
    step(0, 0, 1, 0, 0, 1);
    step(0, 0, 1, 1, 32'h8, 0);
    chk("pre_reset_ls_rsp_valid", ls_rsp_valid, 1);
    if_req_valid = 1; ls_req_valid = 1;
    #2 reset_n = 0;
    if_q.delete(); ls_q.delete();
    held_if = 0; held_ls = 0; losses = 0;
    #1 check_reset_outputs();
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1;
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
